uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART receiver, 8N1, LSB first, runtime-programmable baud rate.
// - Recovers bytes from the serial RX pin and pushes each good byte into the RX FIFO with a 1-cycle write pulse.
// - Mirror of the UART TX path; shares the bode_rate_set register and the 50 MHz system clock.
// PARAMETERS
// - SYS_CLK_FREQ  28'd50_000_000  system clock frequency in Hz; bit period derived from it
// PORTS
// - sys_clk        in   1   system clock
// - sys_rst_n      in   1   reset, asynchronous, active-low
// - RX             in   1   serial input, asynchronous to sys_clk, idles high
// - bode_rate_set  in   20  baud rate in Hz (e.g. 20'd115200); 0 = receiver disabled
// - fifo_full      in   1   RX FIFO full flag
// - fifo_wr_req    out  1   1-cycle write strobe to RX FIFO
// - fifo_wr_data   out  8   received byte, valid while fifo_wr_req=1, held until next write
// - frame_err      out  1   1-cycle pulse: stop bit sampled 0
// - overrun_err    out  1   1-cycle pulse: good byte dropped because fifo_full=1
// - rx_busy        out  1   high from start-edge detect until stop-bit sample
// BEHAVIOUR
// - Reset: all outputs 0; sync flops = 1; FSM = IDLE; counters = 0.
// - RX passes through a 2-FF synchronizer (reset value 1); all logic uses the synced value rx_s.
// - Falling edge = rx_s_d1==1 && rx_s==0.
// - On the start edge, latch bit period N = SYS_CLK_FREQ/bode_rate_set - 1 (28-bit divide, truncated to 20 bits) and H = N>>1.
// - A bode_rate_set change mid-frame has no effect until the next frame.
// - bode_rate_set==0: stay in IDLE, ignore edges (no divide by zero).
// - FSM states: IDLE, START, DATA, STOP. period_cnt 20-bit, bit_cnt 3-bit.
// - IDLE: on falling edge -> START, period_cnt=0, rx_busy=1.
// - START: at period_cnt==H sample rx_s.
//   - 0: -> DATA, period_cnt=0, bit_cnt=0.
//   - 1: glitch -> IDLE, no outputs pulse.
// - DATA: period_cnt counts 0..N and wraps. At period_cnt==N, shift rx_s into the shift reg at bit [bit_cnt] (LSB first).
//   - After bit_cnt==7 is sampled -> STOP, else bit_cnt+1.
// - STOP: at period_cnt==N sample rx_s (mid stop bit), then -> IDLE and rx_busy=0 in the same cycle.
//   - 1 && !fifo_full: next cycle fifo_wr_req=1, fifo_wr_data=byte.
//   - 1 && fifo_full: next cycle overrun_err=1, no write, fifo_wr_data unchanged.
//   - 0: next cycle frame_err=1, no write. Line held low (break) does not retrigger; a new falling edge is required.
// - Latency: fifo_wr_req asserts about 9.5 bit periods + 4 clocks after the RX pin falls.
// - Back-to-back frames are supported: IDLE is re-entered mid stop bit, so the next start edge is caught.
// - fifo_wr_req, frame_err, overrun_err are mutually exclusive and each lasts exactly 1 cycle.
// - Reset mid-frame: abort immediately, no write or error pulse, return to reset values.
// STRUCTURE
// - Shared package uart_pkg:
//   - SYS_CLK_FREQ constant
//   - FSM state encoding (2-bit IDLE/START/DATA/STOP)
//   - DATA_BITS=8
// - Sub-module uart_rx_sync: 2-FF synchronizer plus falling-edge detect (reset to 1). Reusable by other async inputs.
// - Divider for N is combinational from bode_rate_set, registered at the start edge.
// TESTING (50 MHz; 115200 baud -> N=433, H=216)
// - Send 0x55 (clean 8N1) -> exactly one fifo_wr_req pulse, fifo_wr_data=8'h55, no error pulses.
// - Back-to-back 0x00 then 0xFF with no idle gap -> two writes, data 8'h00 then 8'hFF.
// - RX low glitch of 100 clocks (< H) -> return to IDLE, no write, no error, rx_busy drops.
// - Frame 0xA3 with stop bit forced 0 -> frame_err 1-cycle pulse, fifo_wr_req stays 0; next clean frame 0x3C writes 8'h3C.
// - fifo_full=1 during 0x7E -> overrun_err pulse, no write, fifo_wr_data holds previous value.
// - bode_rate_set=9600 (N=5207) sending 0xC9, with sys_rst_n pulsed low at data bit 4 of the prior frame -> aborted frame not written; 0xC9 written correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: system clock rate, receiver FSM encoding and the
// bit-period helper used to turn a baud rate into a clock count.
package uart_pkg;

    localparam logic [27:0] SYS_CLK_FREQ = 28'd50_000_000;
    localparam int          DATA_BITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Clocks per bit minus one; a zero baud is steered to divisor 1 so the
    // divider never sees zero (the FSM refuses to start in that case anyway).
    function automatic logic [19:0] calc_period(input logic [27:0] clk_freq,
                                                input logic [19:0] baud);
        logic [27:0] divisor;
        logic [27:0] quot;
        divisor = (baud == 20'd0) ? 28'd1 : {8'd0, baud};
        quot    = clk_freq / divisor;
        return 20'(quot - 28'd1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input, plus a
// falling-edge strobe taken from the synchronized value.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic din,
    output logic sync_out,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic sync_d1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta    <= 1'b1;
            sync_q  <= 1'b1;
            sync_d1 <= 1'b1;
        end else begin
            meta    <= din;
            sync_q  <= meta;
            sync_d1 <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign fall     = sync_d1 & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with runtime baud rate; each good byte is handed to the
// RX FIFO with a single-cycle write strobe.
module uart_rx #(
    parameter logic [27:0] SYS_CLK_FREQ = uart_pkg::SYS_CLK_FREQ
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        RX,
    input  logic [19:0] bode_rate_set,
    input  logic        fifo_full,
    output logic        fifo_wr_req,
    output logic [7:0]  fifo_wr_data,
    output logic        frame_err,
    output logic        overrun_err,
    output logic        rx_busy
);
    import uart_pkg::*;

    rx_state_e             state;
    rx_state_e             state_nxt;
    logic                  rx_s;
    logic                  rx_fall;
    logic [19:0]           n_calc;
    logic [19:0]           n_lat;
    logic [19:0]           h_lat;
    logic [19:0]           period_cnt;
    logic [2:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shift_reg;

    logic load_period;
    logic cnt_clr;
    logic cnt_inc;
    logic bit_clr;
    logic bit_inc;
    logic sample_data;
    logic stop_done;

    uart_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (RX),
        .sync_out  (rx_s),
        .fall      (rx_fall)
    );

    assign n_calc = calc_period(SYS_CLK_FREQ, bode_rate_set);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load_period = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        bit_clr     = 1'b0;
        bit_inc     = 1'b0;
        sample_data = 1'b0;
        stop_done   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_fall && (bode_rate_set != 20'd0)) begin
                    state_nxt   = ST_START;
                    load_period = 1'b1;
                    cnt_clr     = 1'b1;
                end
            end
            ST_START: begin
                if (period_cnt == h_lat) begin
                    cnt_clr = 1'b1;
                    if (!rx_s) begin
                        state_nxt = ST_DATA;
                        bit_clr   = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DATA: begin
                if (period_cnt == n_lat) begin
                    cnt_clr     = 1'b1;
                    sample_data = 1'b1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = ST_STOP;
                    else                              bit_inc   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_STOP: begin
                // Leave mid stop bit so a back-to-back start edge is not missed.
                if (period_cnt == n_lat) begin
                    cnt_clr   = 1'b1;
                    stop_done = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bit timing is frozen at the start edge; later baud changes wait a frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            n_lat      <= 20'd0;
            h_lat      <= 20'd0;
            period_cnt <= 20'd0;
            bit_cnt    <= 3'd0;
        end else begin
            if (load_period) begin
                n_lat <= n_calc;
                h_lat <= n_calc >> 1;
            end
            if (cnt_clr)      period_cnt <= 20'd0;
            else if (cnt_inc) period_cnt <= period_cnt + 20'd1;
            if (bit_clr)      bit_cnt <= 3'd0;
            else if (bit_inc) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sample_data) shift_reg[bit_cnt] <= rx_s;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_wr_req  <= 1'b0;
            fifo_wr_data <= 8'd0;
            frame_err    <= 1'b0;
            overrun_err  <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            fifo_wr_req <= stop_done && rx_s && !fifo_full;
            overrun_err <= stop_done && rx_s && fifo_full;
            frame_err   <= stop_done && !rx_s;
            rx_busy     <= (state_nxt != ST_IDLE);
            if (stop_done && rx_s && !fifo_full) fifo_wr_data <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, hand-written corner sequences and random
// frames scored against a frame-level model of the receiver.
module tb_uart_rx;

    localparam int CLK_HZ = 50_000_000;
    localparam int NV     = 6;
    localparam int N_RAND = 16;

    logic        sys_clk       = 1'b0;
    logic        sys_rst_n     = 1'b0;
    logic        RX            = 1'b1;
    logic [19:0] bode_rate_set = 20'd115200;
    logic        fifo_full     = 1'b0;
    logic        fifo_wr_req;
    logic [7:0]  fifo_wr_data;
    logic        frame_err;
    logic        overrun_err;
    logic        rx_busy;

    int tests = 0;
    int fails = 0;

    longint     cyc = 0;
    int         n_wr = 0, n_ferr = 0, n_ovr = 0;
    int         excl_viol = 0, width_viol = 0;
    logic [7:0] wr_log [0:255];
    longint     last_wr_cyc = 0;
    logic       prev_wr = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic        full;
        logic [19:0] baud;
        int          exp_wr;
        int          exp_ferr;
        int          exp_ovr;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs [NV];

    uart_rx #(.SYS_CLK_FREQ(28'd50_000_000)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .RX            (RX),
        .bode_rate_set (bode_rate_set),
        .fifo_full     (fifo_full),
        .fifo_wr_req   (fifo_wr_req),
        .fifo_wr_data  (fifo_wr_data),
        .frame_err     (frame_err),
        .overrun_err   (overrun_err),
        .rx_busy       (rx_busy)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (fifo_wr_req) begin
                wr_log[n_wr[7:0]] = fifo_wr_data;
                n_wr++;
                last_wr_cyc = cyc;
            end
            if (frame_err)   n_ferr++;
            if (overrun_err) n_ovr++;
            if ((fifo_wr_req && prev_wr) || (frame_err && prev_fe) || (overrun_err && prev_ov))
                width_viol++;
            if (int'(fifo_wr_req) + int'(frame_err) + int'(overrun_err) > 1)
                excl_viol++;
        end
        prev_wr = fifo_wr_req;
        prev_fe = frame_err;
        prev_ov = overrun_err;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int period_of(input int baud);
        return CLK_HZ / baud;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop, input int p,
                              input logic chg, input logic [19:0] alt);
        RX = 1'b0;
        if (chg) begin
            tick(4);
            bode_rate_set = alt;
            tick(p - 4);
        end else begin
            tick(p);
        end
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            tick(p);
        end
        RX = stop;
        tick(p);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic stop, input logic full,
                             input logic [19:0] baud, input logic chg, input logic [19:0] alt,
                             output int dw, output int dfe, output int dov);
        int w0, f0, o0, p;
        p = period_of(int'(baud));
        bode_rate_set = baud;
        fifo_full = full;
        w0 = n_wr; f0 = n_ferr; o0 = n_ovr;
        send_frame(d, stop, p, chg, alt);
        if (!stop) begin
            tick(2 * p);
            chk("break_no_retrigger", longint'(rx_busy), 0);
            RX = 1'b1;
        end
        tick(p + 10);
        fifo_full = 1'b0;
        bode_rate_set = baud;
        dw = n_wr - w0; dfe = n_ferr - f0; dov = n_ovr - o0;
    endtask

    initial begin
        int         w0, f0, o0, p, dw, dfe, dov;
        longint     t0, lat, lat2;
        logic [7:0] model_last;
        logic [7:0] d;
        logic [7:0] pre;
        logic       stop, full, chg;
        int         rates [3];
        logic [19:0] alts [4];
        int         ew, ef, eo;

        vecs[0] = '{8'h55, 1'b1, 1'b0, 20'd1_000_000, 1, 0, 0, 8'h55};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, 20'd1_000_000, 0, 1, 0, 8'h55};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 20'd1_000_000, 1, 0, 0, 8'h3C};
        vecs[3] = '{8'h7E, 1'b1, 1'b1, 20'd1_000_000, 0, 0, 1, 8'h3C};
        vecs[4] = '{8'h81, 1'b1, 1'b0, 20'd625_000,   1, 0, 0, 8'h81};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 20'd500_000,   1, 0, 0, 8'h00};
        rates[0] = 1_000_000; rates[1] = 625_000; rates[2] = 500_000;
        alts[0] = 20'd0; alts[1] = 20'd9600; alts[2] = 20'd1_000_000; alts[3] = 20'd500_000;

        // reset state
        tick(5);
        chk("reset_wr_req", longint'(fifo_wr_req), 0);
        chk("reset_wr_data", longint'(fifo_wr_data), 0);
        chk("reset_frame_err", longint'(frame_err), 0);
        chk("reset_overrun_err", longint'(overrun_err), 0);
        chk("reset_rx_busy", longint'(rx_busy), 0);
        sys_rst_n = 1'b1;
        tick(5);

        // 0x55 at 115200 with latency check
        bode_rate_set = 20'd115200;
        p = period_of(115200);
        w0 = n_wr; f0 = n_ferr; o0 = n_ovr;
        t0 = cyc;
        send_frame(8'h55, 1'b1, p, 1'b0, 20'd0);
        tick(p + 10);
        chk("b55_writes", n_wr - w0, 1);
        chk("b55_data", longint'(fifo_wr_data), 8'h55);
        chk("b55_errs", (n_ferr - f0) + (n_ovr - o0), 0);
        lat  = last_wr_cyc - t0;
        lat2 = 2 * lat - longint'(19 * p + 8);
        chk("b55_latency_near_9p5_bits", longint'(lat2 >= -4 && lat2 <= 4), 1);

        // short low glitch
        w0 = n_wr; f0 = n_ferr; o0 = n_ovr;
        RX = 1'b0;
        tick(50);
        chk("glitch_busy_high", longint'(rx_busy), 1);
        tick(50);
        RX = 1'b1;
        tick(300);
        chk("glitch_busy_drop", longint'(rx_busy), 0);
        chk("glitch_no_events", (n_wr - w0) + (n_ferr - f0) + (n_ovr - o0), 0);

        // disabled receiver ignores edges
        bode_rate_set = 20'd0;
        w0 = n_wr; f0 = n_ferr; o0 = n_ovr;
        RX = 1'b0;
        tick(20);
        chk("disabled_not_busy", longint'(rx_busy), 0);
        RX = 1'b1;
        tick(20);
        chk("disabled_no_events", (n_wr - w0) + (n_ferr - f0) + (n_ovr - o0), 0);

        // vector table
        for (int i = 0; i < NV; i++) begin
            run_frame(vecs[i].data, vecs[i].stop, vecs[i].full, vecs[i].baud, 1'b0, 20'd0,
                      dw, dfe, dov);
            chk($sformatf("vec%0d_writes", i), dw, vecs[i].exp_wr);
            chk($sformatf("vec%0d_frame_err", i), dfe, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_overrun", i), dov, vecs[i].exp_ovr);
            chk($sformatf("vec%0d_wr_data", i), longint'(fifo_wr_data), longint'(vecs[i].exp_out));
            chk($sformatf("vec%0d_idle", i), longint'(rx_busy), 0);
        end

        // back-to-back frames, no idle gap
        bode_rate_set = 20'd1_000_000;
        p = period_of(1_000_000);
        w0 = n_wr;
        send_frame(8'h00, 1'b1, p, 1'b0, 20'd0);
        send_frame(8'hFF, 1'b1, p, 1'b0, 20'd0);
        tick(p + 10);
        chk("b2b_writes", n_wr - w0, 2);
        chk("b2b_first", longint'(wr_log[w0 % 256]), 8'h00);
        chk("b2b_second", longint'(wr_log[(w0 + 1) % 256]), 8'hFF);
        model_last = 8'hFF;

        // random frames against the frame-level model
        for (int k = 0; k < N_RAND; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            full = ($urandom_range(0, 3) == 0);
            chg  = 1'($urandom_range(0, 1));
            ew = 0; ef = 0; eo = 0;
            if (!stop)     ef = 1;
            else if (full) eo = 1;
            else begin
                ew = 1;
                model_last = d;
            end
            run_frame(d, stop, full, 20'(rates[$urandom_range(0, 2)]), chg,
                      alts[$urandom_range(0, 3)], dw, dfe, dov);
            chk($sformatf("rnd%0d_writes", k), dw, ew);
            chk($sformatf("rnd%0d_frame_err", k), dfe, ef);
            chk($sformatf("rnd%0d_overrun", k), dov, eo);
            chk($sformatf("rnd%0d_wr_data", k), longint'(fifo_wr_data), longint'(model_last));
        end

        // reset during data bit 4, then a clean frame at a new rate
        bode_rate_set = 20'd230400;
        p = period_of(230400);
        pre = 8'h5A;
        w0 = n_wr; f0 = n_ferr; o0 = n_ovr;
        RX = 1'b0;
        tick(p);
        for (int i = 0; i < 4; i++) begin
            RX = pre[i];
            tick(p);
        end
        RX = pre[4];
        tick(p / 2);
        sys_rst_n = 1'b0;
        RX = 1'b1;
        #1;
        chk("abort_busy_cleared", longint'(rx_busy), 0);
        chk("abort_wr_data_cleared", longint'(fifo_wr_data), 0);
        tick(3);
        sys_rst_n = 1'b1;
        tick(2 * p);
        chk("abort_no_events", (n_wr - w0) + (n_ferr - f0) + (n_ovr - o0), 0);
        run_frame(8'hC9, 1'b1, 1'b0, 20'd115200, 1'b0, 20'd0, dw, dfe, dov);
        chk("c9_writes", n_wr - w0, 1);
        chk("c9_data", longint'(fifo_wr_data), 8'hC9);
        chk("c9_errs", dfe + dov, 0);

        chk("pulses_exclusive", excl_viol, 0);
        chk("pulses_one_cycle", width_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
